// File: rtl/bus_arbiter.sv
// Round-robin arbiter that shares one memory bus between instruction fetch (port 0)
// and data access (port 1), with a response timeout so a dead slave cannot hang the core.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  input  logic [2:0]  i_bhw0,
  input  logic [2:0]  i_bhw1,
  input  logic        i_wnr0,
  input  logic        i_wnr1,
  output logic        o_done0,
  output logic        o_done1,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic [1:0]  o_grant,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_data,
  output logic        o_bus_DV,
  output logic [2:0]  o_bhw,
  output logic        o_write_notread,
  input  logic [31:0] i_bus_data,
  input  logic        i_bus_DV
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           state, state_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             any_req, pick, timeout_hit;

  logic [1:0]  grant_nxt;
  logic        done0_nxt, done1_nxt, err_nxt, bus_dv_nxt, wnr_nxt;
  logic [31:0] rdata_nxt, addr_nxt, data_nxt;
  logic [2:0]  bhw_nxt;

  // On a tie the port that did not own the bus last time wins.
  assign any_req     = i_req0 | i_req1;
  assign pick        = (i_req0 && i_req1) ? ~last : i_req1;
  assign timeout_hit = TO_EN && (cnt == TO_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state           <= IDLE;
      last            <= 1'b1;
      cnt             <= '0;
      o_grant         <= 2'b00;
      o_done0         <= 1'b0;
      o_done1         <= 1'b0;
      o_err           <= 1'b0;
      o_bus_DV        <= 1'b0;
      o_rdata         <= '0;
      o_bus_address   <= '0;
      o_bus_data      <= '0;
      o_bhw           <= '0;
      o_write_notread <= 1'b0;
    end else begin
      state           <= state_nxt;
      last            <= last_nxt;
      cnt             <= cnt_nxt;
      o_grant         <= grant_nxt;
      o_done0         <= done0_nxt;
      o_done1         <= done1_nxt;
      o_err           <= err_nxt;
      o_bus_DV        <= bus_dv_nxt;
      o_rdata         <= rdata_nxt;
      o_bus_address   <= addr_nxt;
      o_bus_data      <= data_nxt;
      o_bhw           <= bhw_nxt;
      o_write_notread <= wnr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (i_bus_DV || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a latch behind.
  always_comb begin
    last_nxt   = last;
    cnt_nxt    = cnt;
    grant_nxt  = o_grant;
    done0_nxt  = 1'b0;
    done1_nxt  = 1'b0;
    err_nxt    = 1'b0;
    bus_dv_nxt = 1'b0;
    rdata_nxt  = o_rdata;
    addr_nxt   = o_bus_address;
    data_nxt   = o_bus_data;
    bhw_nxt    = o_bhw;
    wnr_nxt    = o_write_notread;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          last_nxt   = pick;
          grant_nxt  = pick ? 2'b10 : 2'b01;
          addr_nxt   = pick ? i_addr1  : i_addr0;
          data_nxt   = pick ? i_wdata1 : i_wdata0;
          bhw_nxt    = pick ? i_bhw1   : i_bhw0;
          wnr_nxt    = pick ? i_wnr1   : i_wnr0;
          bus_dv_nxt = 1'b1;
        end
      end
      ISSUE: cnt_nxt = '0;
      WAIT: begin
        cnt_nxt = cnt + 1'b1;
        // A response arriving on the timeout cycle still counts as success.
        if (i_bus_DV || timeout_hit) begin
          rdata_nxt = i_bus_DV ? i_bus_data : 32'h0;
          err_nxt   = ~i_bus_DV;
          done0_nxt = o_grant[0];
          done1_nxt = o_grant[1];
          grant_nxt = 2'b00;
        end
      end
      DONE:    ;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed transactions push expected bus requests
// and completions; independent monitors compare whenever the DUT presents them.
module tb_bus_arbiter;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  bhw;
    logic        wnr;
    logic [1:0]  grant;
  } bus_t;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req0 = 1'b0, i_req1 = 1'b0;
  logic [31:0] i_addr0 = '0, i_addr1 = '0, i_wdata0 = '0, i_wdata1 = '0;
  logic [2:0]  i_bhw0 = '0, i_bhw1 = '0;
  logic        i_wnr0 = 1'b0, i_wnr1 = 1'b0;
  logic [31:0] i_bus_data = '0;
  logic        i_bus_DV = 1'b0;
  logic        o_done0, o_done1, o_err, o_bus_DV, o_write_notread;
  logic [31:0] o_rdata, o_bus_address, o_bus_data;
  logic [1:0]  o_grant;
  logic [2:0]  o_bhw;

  resp_t       resp_q[$];
  bus_t        bus_q[$];
  int          tests = 0;
  int          failed = 0;
  int          cyc = 0;
  int          issue_cyc = 0;
  int          slave_delay = 0;
  int          cd = 0;
  logic [31:0] slave_rdata[2];
  logic [31:0] pend_data = '0;
  logic        stray_dv = 1'b0;

  bus_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req0(i_req0), .i_req1(i_req1),
    .i_addr0(i_addr0), .i_addr1(i_addr1),
    .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
    .i_bhw0(i_bhw0), .i_bhw1(i_bhw1),
    .i_wnr0(i_wnr0), .i_wnr1(i_wnr1),
    .o_done0(o_done0), .o_done1(o_done1),
    .o_rdata(o_rdata), .o_err(o_err), .o_grant(o_grant),
    .o_bus_address(o_bus_address), .o_bus_data(o_bus_data),
    .o_bus_DV(o_bus_DV), .o_bhw(o_bhw), .o_write_notread(o_write_notread),
    .i_bus_data(i_bus_data), .i_bus_DV(i_bus_DV)
  );

  always #5 i_clk = ~i_clk;

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_bus(input logic [31:0] a, d, input logic [2:0] b, input logic w,
                            input logic [1:0] g);
    bus_t t;
    t.addr = a; t.data = d; t.bhw = b; t.wnr = w; t.grant = g;
    bus_q.push_back(t);
  endtask

  task automatic expect_resp(input logic p, input logic [31:0] r, input logic e, input int lat);
    resp_t t;
    t.port = p; t.rdata = r; t.err = e; t.lat = lat;
    resp_q.push_back(t);
  endtask

  task automatic set_port(input int p, input logic [31:0] a, d, input logic [2:0] b,
                          input logic w);
    if (p == 0) begin
      i_addr0 = a; i_wdata0 = d; i_bhw0 = b; i_wnr0 = w;
    end else begin
      i_addr1 = a; i_wdata1 = d; i_bhw1 = b; i_wnr1 = w;
    end
  endtask

  task automatic wait_done(input int port, input int budget);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge i_clk);
      seen = (port == 0) ? o_done0 : o_done1;
    end
    check($sformatf("done%0d_seen", port), 32'(seen), 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 32'(o_grant), 32'h0);
    check({tag, "_done0"}, 32'(o_done0), 32'h0);
    check({tag, "_done1"}, 32'(o_done1), 32'h0);
    check({tag, "_err"}, 32'(o_err), 32'h0);
    check({tag, "_bus_dv"}, 32'(o_bus_DV), 32'h0);
    check({tag, "_rdata"}, o_rdata, 32'h0);
    check({tag, "_addr"}, o_bus_address, 32'h0);
    check({tag, "_wdata"}, o_bus_data, 32'h0);
    check({tag, "_bhw"}, 32'(o_bhw), 32'h0);
    check({tag, "_wnr"}, 32'(o_write_notread), 32'h0);
  endtask

  // Slave: answers slave_delay cycles after the o_bus_DV cycle; 0 means never.
  initial forever begin
    @(negedge i_clk);
    i_bus_DV = 1'b0;
    if (stray_dv) begin
      i_bus_DV   = 1'b1;
      i_bus_data = 32'h5555_AAAA;
    end
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        i_bus_DV   = 1'b1;
        i_bus_data = pend_data;
      end
    end
    if (o_bus_DV && slave_delay > 0) begin
      cd        = slave_delay;
      pend_data = o_grant[1] ? slave_rdata[1] : slave_rdata[0];
    end
  end

  // Bus-side monitor: request contents at the strobe, then stability while granted.
  initial begin
    bus_t cur;
    logic cur_valid;
    logic prev_dv;
    cur_valid = 1'b0;
    prev_dv   = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_bus_DV) begin
        check("bus_dv_width", 32'(prev_dv), 32'h0);
        if (bus_q.size() == 0) begin
          check("unexpected_bus_dv", 32'(o_bus_DV), 32'h0);
        end else begin
          cur       = bus_q.pop_front();
          cur_valid = 1'b1;
          issue_cyc = cyc;
          check("bus_addr", o_bus_address, cur.addr);
          check("bus_data", o_bus_data, cur.data);
          check("bus_bhw", 32'(o_bhw), 32'(cur.bhw));
          check("bus_wnr", 32'(o_write_notread), 32'(cur.wnr));
          check("grant", 32'(o_grant), 32'(cur.grant));
        end
      end else if (o_grant != 2'b00 && cur_valid) begin
        check("hold_addr", o_bus_address, cur.addr);
        check("hold_data", o_bus_data, cur.data);
        check("hold_bhw", 32'(o_bhw), 32'(cur.bhw));
        check("hold_wnr", 32'(o_write_notread), 32'(cur.wnr));
        check("hold_grant", 32'(o_grant), 32'(cur.grant));
      end
      prev_dv = o_bus_DV;
    end
  end

  // Completion monitor.
  initial begin
    resp_t r;
    forever begin
      @(negedge i_clk);
      if (o_done0 || o_done1) begin
        check("done_overlap", 32'(o_done0 & o_done1), 32'h0);
        if (resp_q.size() == 0) begin
          check("unexpected_done", 32'({o_done1, o_done0}), 32'h0);
        end else begin
          r = resp_q.pop_front();
          check("done_port", 32'(o_done1), 32'(r.port));
          check("rdata", o_rdata, r.rdata);
          check("err", 32'(o_err), 32'(r.err));
          if (r.lat >= 0) check("latency", 32'(cyc - issue_cyc), 32'(r.lat));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    slave_rdata[0] = 32'h0000_AAAA;
    slave_rdata[1] = 32'h0000_BBBB;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("reset");

    // Both ports straight out of reset: port 0 first, then strict alternation.
    set_port(0, 32'h0000_0100, 32'h0, 3'b010, 1'b0);
    set_port(1, 32'h0000_0200, 32'h1111_2222, 3'b010, 1'b1);
    slave_delay = 1;
    for (int k = 0; k < 2; k++) begin
      expect_bus(32'h0000_0100, 32'h0, 3'b010, 1'b0, 2'b01);
      expect_resp(1'b0, 32'h0000_AAAA, 1'b0, 2);
      expect_bus(32'h0000_0200, 32'h1111_2222, 3'b010, 1'b1, 2'b10);
      expect_resp(1'b1, 32'h0000_BBBB, 1'b0, 2);
    end
    i_reset = 1'b0;
    i_req0  = 1'b1;
    i_req1  = 1'b1;
    wait_done(0, 20);
    wait_done(1, 20);
    wait_done(0, 20);
    wait_done(1, 20);
    i_req0 = 1'b0;
    i_req1 = 1'b0;
    repeat (3) @(negedge i_clk);

    // Single read on port 0, slave answers 3 cycles after the strobe.
    slave_rdata[0] = 32'hDEAD_BEEF;
    set_port(0, 32'h0000_0010, 32'h0, 3'b010, 1'b0);
    slave_delay = 3;
    expect_bus(32'h0000_0010, 32'h0, 3'b010, 1'b0, 2'b01);
    expect_resp(1'b0, 32'hDEAD_BEEF, 1'b0, 4);
    i_req0 = 1'b1;
    wait_done(0, 20);
    i_req0 = 1'b0;
    repeat (2) @(negedge i_clk);

    // Write on port 1 with a 1-cycle slave.
    slave_rdata[1] = 32'h0BAD_F00D;
    set_port(1, 32'h0000_2000, 32'h1234_5678, 3'b010, 1'b1);
    slave_delay = 1;
    expect_bus(32'h0000_2000, 32'h1234_5678, 3'b010, 1'b1, 2'b10);
    expect_resp(1'b1, 32'h0BAD_F00D, 1'b0, 2);
    i_req1 = 1'b1;
    wait_done(1, 20);
    i_req1 = 1'b0;
    repeat (2) @(negedge i_clk);

    // Dead slave: abort after 8 WAIT cycles with error and zero data.
    set_port(0, 32'h0000_0030, 32'hFFFF_0000, 3'b000, 1'b0);
    slave_delay = 0;
    expect_bus(32'h0000_0030, 32'hFFFF_0000, 3'b000, 1'b0, 2'b01);
    expect_resp(1'b0, 32'h0, 1'b1, 9);
    i_req0 = 1'b1;
    wait_done(0, 30);
    i_req0 = 1'b0;
    repeat (2) @(negedge i_clk);

    // Response on the 8th WAIT cycle beats the timeout.
    slave_rdata[0] = 32'h600D_DA7A;
    set_port(0, 32'h0000_0034, 32'h0, 3'b010, 1'b0);
    slave_delay = 8;
    expect_bus(32'h0000_0034, 32'h0, 3'b010, 1'b0, 2'b01);
    expect_resp(1'b0, 32'h600D_DA7A, 1'b0, 9);
    i_req0 = 1'b1;
    wait_done(0, 30);
    i_req0 = 1'b0;
    repeat (2) @(negedge i_clk);

    // Stray response strobe while idle must be ignored.
    stray_dv = 1'b1;
    @(negedge i_clk);
    stray_dv = 1'b0;
    repeat (3) @(negedge i_clk);
    check("stray_grant", 32'(o_grant), 32'h0);
    check("stray_bus_dv", 32'(o_bus_DV), 32'h0);
    check("stray_rdata", o_rdata, 32'h600D_DA7A);

    // Reset in WAIT aborts without a completion.
    set_port(0, 32'h0000_0040, 32'h0, 3'b010, 1'b0);
    slave_delay = 0;
    expect_bus(32'h0000_0040, 32'h0, 3'b010, 1'b0, 2'b01);
    i_req0 = 1'b1;
    for (int n = 0; n < 10 && !o_bus_DV; n++) @(negedge i_clk);
    check("reset_txn_issued", 32'(o_bus_DV), 32'h1);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    i_req0  = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b0;
    check_reset_outputs("abort");

    // Tie after reset goes to port 0 even though port 0 owned the bus last.
    slave_rdata[0] = 32'h5050_5050;
    slave_rdata[1] = 32'h6060_6060;
    set_port(0, 32'h0000_0050, 32'h0, 3'b010, 1'b0);
    set_port(1, 32'h0000_0060, 32'hA5A5_A5A5, 3'b001, 1'b1);
    slave_delay = 2;
    expect_bus(32'h0000_0050, 32'h0, 3'b010, 1'b0, 2'b01);
    expect_resp(1'b0, 32'h5050_5050, 1'b0, 3);
    expect_bus(32'h0000_0060, 32'hA5A5_A5A5, 3'b001, 1'b1, 2'b10);
    expect_resp(1'b1, 32'h6060_6060, 1'b0, 3);
    i_req0 = 1'b1;
    i_req1 = 1'b1;
    wait_done(0, 20);
    i_req0 = 1'b0;
    wait_done(1, 20);
    i_req1 = 1'b0;

    repeat (5) @(negedge i_clk);
    check("bus_q_empty", 32'(bus_q.size()), 32'h0);
    check("resp_q_empty", 32'(resp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
